// File: rtl/pu_alu_pkg.sv
// Shared types, opcode encodings and the combinational ALU for the PU ALU/MDU block.
`ifndef PU_WIDTH_NBITS
`define PU_WIDTH_NBITS 32
`endif

package pu_alu_pkg;

  // Widest datapath the shared ALU function supports.
  localparam int ALU_XLEN = 64;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIN
  } state_t;

  // ALU group (m_op = 0)
  localparam logic [2:0] F3_ADD    = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  // Multiply/divide group (m_op = 1)
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Operands arrive zero-extended from 'width' bits; the caller keeps the low 'width' bits.
  function automatic logic [ALU_XLEN-1:0] alu_comb(
    input logic [ALU_XLEN-1:0] in_a,
    input logic [ALU_XLEN-1:0] in_b,
    input logic [2:0]          f3,
    input logic                f5_3,
    input int                  width
  );
    logic [ALU_XLEN-1:0] mask;
    logic [ALU_XLEN-1:0] sbit;
    logic [ALU_XLEN-1:0] a_sx;
    logic [ALU_XLEN-1:0] b_sx;
    logic [ALU_XLEN-1:0] res;
    logic [5:0]          sh;
    mask = (ALU_XLEN'(1) << width) - ALU_XLEN'(1);
    sbit = ALU_XLEN'(1) << (width - 1);
    a_sx = (|(in_a & sbit)) ? (in_a | ~mask) : in_a;
    b_sx = (|(in_b & sbit)) ? (in_b | ~mask) : in_b;
    sh   = in_b[5:0] & 6'(width - 1);
    res  = '0;
    case (f3)
      F3_ADD:  res = f5_3 ? (in_a - in_b) : (in_a + in_b);
      F3_SLL:  res = in_a << sh;
      F3_SLT:  res = ALU_XLEN'($signed(a_sx) < $signed(b_sx));
      F3_SLTU: res = ALU_XLEN'(in_a < in_b);
      F3_XOR:  res = in_a ^ in_b;
      F3_SR: begin
        // Kept as separate statements so the arithmetic shift stays in a signed context.
        if (f5_3) res = $signed(a_sx) >>> sh;
        else      res = in_a >> sh;
      end
      F3_OR:   res = in_a | in_b;
      F3_AND:  res = in_a & in_b;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pu_mdu_iter.sv
// Iterative multiply (shift-add) and restoring divide datapath, one bit per step,
// operating on magnitudes with sign correction folded into the final result.
module pu_mdu_iter
  import pu_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             start,
  input  logic             step,
  input  logic [2:0]       f3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
);

  logic [2:0]       op;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;

  logic             a_neg_in;
  logic             b_neg_in;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] lo_n;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               unused_diff;

  assign a_neg_in = a[WIDTH-1] &&
                    (f3 == F3_MULH || f3 == F3_MULHSU || f3 == F3_DIV || f3 == F3_REM);
  assign b_neg_in = b[WIDTH-1] && (f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM);
  assign a_mag    = a_neg_in ? -a : a;
  assign b_mag    = b_neg_in ? -b : b;

  // NOTE: pure datapath registers have no reset; every op reloads them on start, and
  // the control FSM in the top never consumes them before that.
  always_ff @(posedge clk) begin
    if (start) begin
      op    <= f3;
      a_neg <= a_neg_in;
      b_neg <= b_neg_in;
      acc   <= '0;
      lo    <= f3[2] ? a_mag : b_mag;
      mcand <= f3[2] ? b_mag : a_mag;
    end else if (step) begin
      acc <= acc_n;
      lo  <= lo_n;
    end
  end

  // mul: {acc,lo} is the partial product with the multiplier shifting out of lo.
  // div: acc is the running remainder, lo shifts dividend bits out and quotient bits in.
  always_comb begin
    sum     = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
    shifted = {acc, lo[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, mcand};
    acc_n   = sum[WIDTH:1];
    lo_n    = {sum[0], lo[WIDTH-1:1]};
    if (op[2]) begin
      if (diff[WIDTH+1]) begin
        acc_n = shifted[WIDTH-1:0];
        lo_n  = {lo[WIDTH-2:0], 1'b0};
      end else begin
        acc_n = diff[WIDTH-1:0];
        lo_n  = {lo[WIDTH-2:0], 1'b1};
      end
    end
  end

  // A restored remainder is always below the divisor, so this bit never carries information.
  assign unused_diff = diff[WIDTH];

  // Result reflects the step being taken this cycle so the last step and sign fix share one edge.
  assign prod     = {acc_n, lo_n};
  assign prod_fix = (a_neg ^ b_neg) ? -prod : prod;
  assign quo_fix  = (a_neg ^ b_neg) ? -lo_n : lo_n;
  assign rem_fix  = a_neg ? -acc_n : acc_n;

  always_comb begin
    case (op)
      F3_MUL:                      result = prod_fix[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix[2*WIDTH-1:WIDTH];
      F3_DIV, F3_DIVU:             result = quo_fix;
      default:                     result = rem_fix;
    endcase
  end

endmodule

// File: rtl/pu_alu_mdu.sv
// PU ALU with registered result, valid/ready handshake and iterative RV32M-style mul/div.
module pu_alu_mdu
  import pu_alu_pkg::*;
#(
  parameter int WIDTH     = `PU_WIDTH_NBITS,
  parameter int SH_NBITS  = $clog2(WIDTH),
  parameter int IMM_WIDTH = `PU_WIDTH_NBITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 use_imm,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic [WIDTH-1:0]     rs1,
  input  logic [WIDTH-1:0]     rs2,
  input  logic [2:0]           funct3,
  input  logic [4:0]           funct5,
  input  logic                 m_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     alu,
  output logic                 busy
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t              state;
  state_t              state_n;
  logic [SH_NBITS-1:0] cnt;
  logic [SH_NBITS-1:0] cnt_n;
  logic                out_valid_n;
  logic [WIDTH-1:0]    alu_n;

  logic [WIDTH-1:0]    opb;
  logic                accept;
  logic                div_zero;
  logic                div_ovf;
  logic                mdu_start;
  logic                mdu_step;
  logic [WIDTH-1:0]    mdu_result;
  logic                unused_funct5;

  assign opb      = use_imm ? WIDTH'(imm) : rs2;
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // Divide corner cases are resolved at accept and never enter the iterative path.
  assign div_zero = (opb == '0);
  assign div_ovf  = !funct3[0] && (rs1 == MIN_NEG) && (opb == '1);

  assign unused_funct5 = ^{funct5[4], funct5[2:0]};

  pu_mdu_iter #(
    .WIDTH (WIDTH)
  ) u_mdu_iter (
    .clk    (clk),
    .start  (mdu_start),
    .step   (mdu_step),
    .f3     (funct3),
    .a      (rs1),
    .b      (opb),
    .result (mdu_result)
  );

  // NOTE: every output of this block gets a default before the case, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    out_valid_n = out_valid && !out_ready;
    alu_n       = alu;
    mdu_start   = 1'b0;
    mdu_step    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          out_valid_n = 1'b1;
          if (!m_op) begin
            alu_n = WIDTH'(alu_comb(ALU_XLEN'(rs1), ALU_XLEN'(opb), funct3, funct5[3], WIDTH));
          end else if (funct3[2] && div_zero) begin
            alu_n = funct3[1] ? rs1 : '1;
          end else if (funct3[2] && div_ovf) begin
            alu_n = funct3[1] ? '0 : rs1;
          end else begin
            out_valid_n = 1'b0;
            mdu_start   = 1'b1;
            cnt_n       = SH_NBITS'(WIDTH - 1);
            state_n     = funct3[2] ? DIV : MUL;
          end
        end
      end
      MUL, DIV: begin
        // WIDTH-1 steps here; the final step runs in FIN together with the sign fix.
        mdu_step = 1'b1;
        cnt_n    = cnt - SH_NBITS'(1);
        if (cnt == SH_NBITS'(1)) state_n = FIN;
      end
      FIN: begin
        mdu_step    = 1'b1;
        alu_n       = mdu_result;
        out_valid_n = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // values from before the edge regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      alu       <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      out_valid <= out_valid_n;
      alu       <= alu_n;
    end
  end

endmodule
